// File: rtl/crc16_rx_chk.sv
// rtl/crc16_rx_chk.sv - USB DATA-packet receive stage: PID check, PID/CRC strip, on-the-fly CRC16 check
// Payload is delayed two bytes in a hold buffer so the trailing CRC bytes never reach the link side.

module crc16_byte_upd (
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);
  logic [15:0] c;

  always_comb begin
    c = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    crc_out = c;
  end
endmodule

module crc16_rx_chk #(
  parameter int          MAX_LEN = 1023,
  parameter int          LEN_W   = 11,
  parameter bit          CHK_PID = 1'b1,
  parameter logic [15:0] RESIDUE = 16'hB001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_data_on,
  input  logic             rx_sop,
  input  logic             rx_eop,
  input  logic             rx_valid,
  output logic             rx_ready,
  input  logic [7:0]       rx_data,
  output logic             rx_lt_sop,
  output logic             rx_lt_eop,
  output logic             rx_lt_valid,
  input  logic             rx_lt_ready,
  output logic [7:0]       rx_lt_data,
  output logic             rx_lt_abort,
  output logic             rx_done,
  output logic             rx_crc_ok,
  output logic             rx_err_pid,
  output logic             rx_err_short,
  output logic             rx_err_len,
  output logic             rx_err_abort,
  output logic [LEN_W-1:0] rx_len,
  output logic [3:0]       rx_pid
);
  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  state_t           state_q, state_d;
  logic [15:0]      crc_q, crc_d, crc_nx;
  logic [7:0]       h0_q, h0_d, h1_q, h1_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             started_q, started_d;
  logic             perr_pid_q, perr_pid_d, perr_len_q, perr_len_d;
  logic             ov_q, ov_d, osop_q, osop_d, oeop_q, oeop_d;
  logic [7:0]       od_q, od_d;
  logic             done_q, done_d, abort_q, abort_d;
  logic             crc_ok_q, crc_ok_d, e_pid_q, e_pid_d, e_short_q, e_short_d;
  logic             e_len_q, e_len_d, e_abort_q, e_abort_d;
  logic [LEN_W-1:0] len_out_q, len_out_d;
  logic [3:0]       pid_q, pid_d;
  logic             acc, pid_ok;

  crc16_byte_upd u_crc (.crc_in(crc_q), .data(rx_data), .crc_out(crc_nx));

  assign rx_ready = rx_data_on & (~ov_q | rx_lt_ready);
  assign acc      = rx_valid & rx_ready;
  assign pid_ok   = (rx_data[1:0] == 2'b11) && (!CHK_PID || (rx_data[7:4] == ~rx_data[3:0]));

  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    h0_d       = h0_q;
    h1_d       = h1_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    started_d  = started_q;
    perr_pid_d = perr_pid_q;
    perr_len_d = perr_len_q;
    ov_d       = ov_q;
    od_d       = od_q;
    osop_d     = osop_q;
    oeop_d     = oeop_q;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    crc_ok_d   = crc_ok_q;
    e_pid_d    = e_pid_q;
    e_short_d  = e_short_q;
    e_len_d    = e_len_q;
    e_abort_d  = e_abort_q;
    len_out_d  = len_out_q;
    pid_d      = pid_q;

    if (ov_q && rx_lt_ready) ov_d = 1'b0;

    if (state_q != IDLE && !rx_data_on) begin
      done_d    = 1'b1;
      abort_d   = started_q;
      e_abort_d = 1'b1;
      e_pid_d   = perr_pid_q;
      e_len_d   = perr_len_q;
      e_short_d = 1'b0;
      crc_ok_d  = 1'b0;
      len_out_d = len_q;
      state_d   = IDLE;
      cnt_d     = 2'd0;
      started_d = 1'b0;
    end else if (acc) begin
      if (rx_sop) begin
        // A new PID while a packet is open closes the old one as aborted.
        if (state_q != IDLE) begin
          done_d    = 1'b1;
          abort_d   = started_q;
          e_abort_d = 1'b1;
          e_pid_d   = perr_pid_q;
          e_len_d   = perr_len_q;
          e_short_d = 1'b0;
          crc_ok_d  = 1'b0;
          len_out_d = len_q;
        end
        pid_d      = rx_data[3:0];
        crc_d      = 16'hFFFF;
        cnt_d      = 2'd0;
        len_d      = '0;
        started_d  = 1'b0;
        perr_pid_d = !pid_ok;
        perr_len_d = 1'b0;
        if (rx_eop) begin
          done_d    = 1'b1;
          e_short_d = 1'b1;
          e_pid_d   = !pid_ok;
          e_len_d   = 1'b0;
          e_abort_d = (state_q != IDLE);
          crc_ok_d  = 1'b0;
          len_out_d = '0;
          state_d   = IDLE;
        end else begin
          state_d = pid_ok ? RECV : DROP;
        end
      end else begin
        case (state_q)
          RECV: begin
            crc_d = crc_nx;
            if (rx_eop) begin
              // cnt_q counts bytes before this one: 0 means only one CRC byte arrived.
              done_d    = 1'b1;
              state_d   = IDLE;
              cnt_d     = 2'd0;
              started_d = 1'b0;
              e_pid_d   = 1'b0;
              e_abort_d = 1'b0;
              e_len_d   = 1'b0;
              e_short_d = (cnt_q == 2'd0);
              crc_ok_d  = (cnt_q != 2'd0) && (crc_nx == RESIDUE);
              len_out_d = len_q;
              if (cnt_q == 2'd2) begin
                if (len_q == MAX_L) begin
                  e_len_d = 1'b1;
                  abort_d = started_q;
                end else begin
                  ov_d      = 1'b1;
                  od_d      = h0_q;
                  osop_d    = !started_q;
                  oeop_d    = 1'b1;
                  len_out_d = len_q + 1'b1;
                end
              end
            end else if (cnt_q != 2'd2) begin
              if (cnt_q == 2'd0) h0_d = rx_data;
              else               h1_d = rx_data;
              cnt_d = cnt_q + 2'd1;
            end else if (len_q == MAX_L) begin
              perr_len_d = 1'b1;
              abort_d    = started_q;
              started_d  = 1'b0;
              state_d    = DROP;
            end else begin
              ov_d      = 1'b1;
              od_d      = h0_q;
              osop_d    = !started_q;
              oeop_d    = 1'b0;
              started_d = 1'b1;
              len_d     = len_q + 1'b1;
              h0_d      = h1_q;
              h1_d      = rx_data;
            end
          end
          DROP: begin
            if (rx_eop) begin
              done_d    = 1'b1;
              state_d   = IDLE;
              e_pid_d   = perr_pid_q;
              e_len_d   = perr_len_q;
              e_short_d = 1'b0;
              e_abort_d = 1'b0;
              crc_ok_d  = 1'b0;
              len_out_d = len_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      crc_q      <= 16'hFFFF;
      h0_q       <= 8'h00;
      h1_q       <= 8'h00;
      cnt_q      <= 2'd0;
      len_q      <= '0;
      started_q  <= 1'b0;
      perr_pid_q <= 1'b0;
      perr_len_q <= 1'b0;
      ov_q       <= 1'b0;
      od_q       <= 8'h00;
      osop_q     <= 1'b0;
      oeop_q     <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      crc_ok_q   <= 1'b0;
      e_pid_q    <= 1'b0;
      e_short_q  <= 1'b0;
      e_len_q    <= 1'b0;
      e_abort_q  <= 1'b0;
      len_out_q  <= '0;
      pid_q      <= 4'h0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      h0_q       <= h0_d;
      h1_q       <= h1_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      started_q  <= started_d;
      perr_pid_q <= perr_pid_d;
      perr_len_q <= perr_len_d;
      ov_q       <= ov_d;
      od_q       <= od_d;
      osop_q     <= osop_d;
      oeop_q     <= oeop_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
      crc_ok_q   <= crc_ok_d;
      e_pid_q    <= e_pid_d;
      e_short_q  <= e_short_d;
      e_len_q    <= e_len_d;
      e_abort_q  <= e_abort_d;
      len_out_q  <= len_out_d;
      pid_q      <= pid_d;
    end
  end

  assign rx_lt_valid  = ov_q;
  assign rx_lt_data   = od_q;
  assign rx_lt_sop    = ov_q & osop_q;
  assign rx_lt_eop    = ov_q & oeop_q;
  assign rx_lt_abort  = abort_q;
  assign rx_done      = done_q;
  assign rx_crc_ok    = crc_ok_q;
  assign rx_err_pid   = e_pid_q;
  assign rx_err_short = e_short_q;
  assign rx_err_len   = e_len_q;
  assign rx_err_abort = e_abort_q;
  assign rx_len       = len_out_q;
  assign rx_pid       = pid_q;
endmodule
